mesi_isc_tb_snoop_resp: RTL and testbench
=========================================

// Module: mesi_isc_tb_snoop_resp
// PURPOSE
// Snoop-side responder of the bench CPU model: consumes coherence-bus broadcasts (cbus) driven by
// the MESI intercache block, updates the per-line cache_state array, performs dirty writebacks and
// acks each broadcast. It owns the cache_state array that the coherence assertion checker observes.
// Four instances (cpu0..cpu3) sit between mesi_isc cbus outputs and the bench memory model.
// PARAMETERS
// LINES      10  number of cache lines / addresses tracked (addr 0..LINES-1)
// ADDR_W     4   width of cbus/request address
// WB_CYCLES  3   cycles mem_wr_o is held for a dirty-line writeback (>=1)
// PORTS
// clk                 in   1        clock, all logic on rising edge
// rst                 in   1        async active-high reset
// cbus_cmd_i          in   3        broadcast: 0 NOP, 1 WR_SNOOP, 2 RD_SNOOP, 3 EN_WR, 4 EN_RD
// cbus_addr_i         in   ADDR_W   line addressed by cbus_cmd_i
// cbus_ack_o          out  1        one-cycle ack of current broadcast
// req_wr_i            in   1        CPU main FSM issued write request (1-cycle pulse)
// req_rd_i            in   1        CPU main FSM issued read request (1-cycle pulse)
// req_addr_i          in   ADDR_W   address of req_wr_i/req_rd_i
// wr_proc_wait_for_en out  1        write pending, waiting for EN_WR
// rd_proc_wait_for_en out  1        read pending, waiting for EN_RD
// mem_wr_o            out  1        writeback strobe to memory model
// mem_addr_o          out  ADDR_W   writeback address
// cache_state         out  4xLINES  per-line MESI: M=4'b1001 E=4'b0101 S=4'b0011 I=4'b0000
// snoop_hit_cnt_o     out  16       count of snoops that found line in M/E/S (saturating)
// BEHAVIOUR
// - Reset (async): all cache_state=I, all outputs 0, pending flags cleared, FSM->IDLE, counter 0.
// - FSM states IDLE, WB, ACK, WAIT_NOP.
// - IDLE, cbus_cmd_i==NOP: stay. Non-NOP: latch cmd/addr, evaluate next cycle:
//   WR_SNOOP: M -> WB then line I; E/S -> line I, ACK; I -> ACK, no change.
//   RD_SNOOP: M -> WB then line S; E -> S; S/I unchanged; -> ACK.
//   EN_WR: line M, clear wr_proc_wait_for_en; -> ACK. EN_RD: line E if was I else unchanged,
//   clear rd_proc_wait_for_en; -> ACK. EN_* with no matching pending flag: state untouched, still ACK.
// - WB: mem_wr_o=1, mem_addr_o=latched addr for exactly WB_CYCLES cycles; state update on exit; ->ACK.
// - ACK: cbus_ack_o=1 for one cycle; -> WAIT_NOP. Latency NOP->ack: 2 cycles (no WB), 2+WB_CYCLES (WB).
// - WAIT_NOP: ignore cbus until cbus_cmd_i==NOP, then IDLE; back-to-back command without NOP is
//   never acked twice.
// - cbus_addr_i >= LINES: no state change, no WB, still acked (keeps ISC from deadlock).
// - Changes to cbus_cmd_i/addr while not IDLE are ignored (latched copy used).
// - req_wr_i sets wr_proc_wait_for_en and latches req addr; req_rd_i likewise for rd flag; both
//   high same cycle: write wins, read dropped. New request while flag set: ignored.
// - EN_WR/EN_RD address must equal latched req addr to clear flag; mismatch -> treated as no pending.
// - Request pulse same cycle as matching EN_* latch: request first, EN then consumes it.
// - snoop_hit_cnt_o +1 per WR/RD_SNOOP finding non-I line; saturates at 16'hFFFF.
// - Reset mid-WB or mid-ACK: everything returns to reset values immediately; no ack emitted.
// TESTING
// - Reset: rst=1 2 cycles -> all 10 lines I, cbus_ack_o=0, flags 0.
// - req_wr_i addr 3, then EN_WR addr 3 -> ack 2 cycles later, line3=M, wr flag 0.
// - line3=M, WR_SNOOP addr 3 -> mem_wr_o 3 cycles addr 3, then ack, line3=I, hit_cnt=1.
// - req_rd_i addr 5, EN_RD addr 5 -> line5=E; RD_SNOOP addr 5 -> line5=S, no mem_wr_o.
// - Hold WR_SNOOP addr 7 (line I) 6 cycles w/o NOP -> exactly one ack, line7 stays I.
// - Reset asserted in WB cycle 2 -> mem_wr_o drops same cycle, no ack, all lines I.

Source files
------------

// File: rtl/mesi_isc_tb_snoop_resp.sv
// Snoop-side responder of the bench CPU model: consumes cbus broadcasts, keeps the per-line
// MESI state array, performs dirty writebacks and acks each broadcast exactly once.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a broadcast; eval_q marks a latched one to evaluate
// WB       | dirty writeback in progress, mem_wr_o high
// ACK      | cbus_ack_o high for one cycle
// WAIT_NOP | broadcast acked, waiting for cbus to return to NOP
module mesi_isc_tb_snoop_resp #(
  parameter int LINES     = 10,
  parameter int ADDR_W    = 4,
  parameter int WB_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              cbus_cmd_i,
  input  logic [ADDR_W-1:0]       cbus_addr_i,
  output logic                    cbus_ack_o,
  input  logic                    req_wr_i,
  input  logic                    req_rd_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  output logic                    wr_proc_wait_for_en,
  output logic                    rd_proc_wait_for_en,
  output logic                    mem_wr_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [LINES-1:0][3:0]   cache_state,
  output logic [15:0]             snoop_hit_cnt_o
);

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  localparam logic [3:0] MESI_M = 4'b1001;
  localparam logic [3:0] MESI_E = 4'b0101;
  localparam logic [3:0] MESI_S = 4'b0011;
  localparam logic [3:0] MESI_I = 4'b0000;

  localparam int              CW      = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;
  localparam logic [CW-1:0]   WB_LOAD = CW'(WB_CYCLES - 1);
  localparam logic [ADDR_W:0] LINES_W = (ADDR_W + 1)'(LINES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_ACK,
    ST_WAIT_NOP
  } state_t;

  state_t                   state_q, state_d;
  logic                     eval_q, eval_d;
  logic [2:0]               cmd_q, cmd_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [CW-1:0]            wb_cnt_q, wb_cnt_d;
  logic [LINES-1:0][3:0]    cache_q, cache_d;
  logic                     wr_pend_q, wr_pend_d;
  logic                     rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [15:0]              hit_cnt_q, hit_cnt_d;

  logic                     in_range;
  logic [3:0]               line_cur;
  logic                     is_snoop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      eval_q    <= 1'b0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      wb_cnt_q  <= '0;
      cache_q   <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      eval_q    <= eval_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wb_cnt_q  <= wb_cnt_d;
      cache_q   <= cache_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    eval_d    = eval_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wb_cnt_d  = wb_cnt_q;
    cache_d   = cache_q;
    wr_pend_d = wr_pend_q;
    rd_pend_d = rd_pend_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    hit_cnt_d = hit_cnt_q;

    in_range = ({1'b0, addr_q} < LINES_W);
    line_cur = in_range ? cache_q[addr_q] : MESI_I;
    is_snoop = (cmd_q == CMD_WR_SNOOP) || (cmd_q == CMD_RD_SNOOP);

    // A simultaneous read request is dropped even if the write itself is ignored.
    if (req_wr_i) begin
      if (!wr_pend_q) begin
        wr_pend_d = 1'b1;
        wr_addr_d = req_addr_i;
      end
    end else if (req_rd_i && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = req_addr_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (!eval_q) begin
          if (cbus_cmd_i != CMD_NOP) begin
            cmd_d  = cbus_cmd_i;
            addr_d = cbus_addr_i;
            eval_d = 1'b1;
          end
        end else begin
          eval_d  = 1'b0;
          state_d = ST_ACK;
          if (in_range) begin
            if (is_snoop && (line_cur != MESI_I) && (hit_cnt_q != 16'hFFFF)) begin
              hit_cnt_d = hit_cnt_q + 16'd1;
            end
            case (cmd_q)
              CMD_WR_SNOOP: begin
                if (line_cur == MESI_M) begin
                  state_d  = ST_WB;
                  wb_cnt_d = WB_LOAD;
                end else begin
                  cache_d[addr_q] = MESI_I;
                end
              end
              CMD_RD_SNOOP: begin
                if (line_cur == MESI_M) begin
                  state_d  = ST_WB;
                  wb_cnt_d = WB_LOAD;
                end else if (line_cur == MESI_E) begin
                  cache_d[addr_q] = MESI_S;
                end
              end
              CMD_EN_WR: begin
                if (wr_pend_q && (wr_addr_q == addr_q)) begin
                  cache_d[addr_q] = MESI_M;
                  wr_pend_d       = 1'b0;
                end
              end
              CMD_EN_RD: begin
                if (rd_pend_q && (rd_addr_q == addr_q)) begin
                  if (line_cur == MESI_I) begin
                    cache_d[addr_q] = MESI_E;
                  end
                  rd_pend_d = 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_WB: begin
        if (wb_cnt_q == '0) begin
          state_d         = ST_ACK;
          cache_d[addr_q] = (cmd_q == CMD_WR_SNOOP) ? MESI_I : MESI_S;
        end else begin
          wb_cnt_d = wb_cnt_q - 1'b1;
        end
      end

      ST_ACK: state_d = ST_WAIT_NOP;

      ST_WAIT_NOP: begin
        if (cbus_cmd_i == CMD_NOP) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cbus_ack_o          = (state_q == ST_ACK);
  assign mem_wr_o            = (state_q == ST_WB);
  assign mem_addr_o          = mem_wr_o ? addr_q : '0;
  assign wr_proc_wait_for_en = wr_pend_q;
  assign rd_proc_wait_for_en = rd_pend_q;
  assign cache_state         = cache_q;
  assign snoop_hit_cnt_o     = hit_cnt_q;

endmodule

// File: tb/tb_mesi_isc_tb_snoop_resp.sv
// Directed-vector bench for mesi_isc_tb_snoop_resp: request/enable flow, snoops, writeback,
// repeated broadcasts without NOP, out-of-range addresses and reset during writeback.
module tb_mesi_isc_tb_snoop_resp;

  localparam logic [2:0] NOP = 3'd0, WRS = 3'd1, RDS = 3'd2, ENW = 3'd3, ENR = 3'd4;
  localparam logic [3:0] M = 4'b1001, E = 4'b0101, S = 4'b0011, I = 4'b0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        cbus_cmd_i;
  logic [3:0]        cbus_addr_i;
  logic              cbus_ack_o;
  logic              req_wr_i, req_rd_i;
  logic [3:0]        req_addr_i;
  logic              wr_proc_wait_for_en, rd_proc_wait_for_en;
  logic              mem_wr_o;
  logic [3:0]        mem_addr_o;
  logic [9:0][3:0]   cache_state;
  logic [15:0]       snoop_hit_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  int   wb_n, ack_at, ack_n;
  logic addr_ok;

  mesi_isc_tb_snoop_resp #(.LINES(10), .ADDR_W(4), .WB_CYCLES(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cbus_cmd_i          (cbus_cmd_i),
    .cbus_addr_i         (cbus_addr_i),
    .cbus_ack_o          (cbus_ack_o),
    .req_wr_i            (req_wr_i),
    .req_rd_i            (req_rd_i),
    .req_addr_i          (req_addr_i),
    .wr_proc_wait_for_en (wr_proc_wait_for_en),
    .rd_proc_wait_for_en (rd_proc_wait_for_en),
    .mem_wr_o            (mem_wr_o),
    .mem_addr_o          (mem_addr_o),
    .cache_state         (cache_state),
    .snoop_hit_cnt_o     (snoop_hit_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a broadcast for `hold` cycles, then NOP; observes 12 cycles in total.
  task automatic run_cmd(input logic [2:0] c, input logic [3:0] a, input int hold,
                         output int wb, output int at, output int acks, output logic aok);
    wb = 0; at = 0; acks = 0; aok = 1'b1;
    cbus_cmd_i  = c;
    cbus_addr_i = a;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (mem_wr_o) begin
        wb++;
        if (mem_addr_o !== a) aok = 1'b0;
      end
      if (cbus_ack_o) begin
        acks++;
        if (at == 0) at = i;
      end
      if (i == hold) cbus_cmd_i = NOP;
    end
    cbus_cmd_i = NOP;
  endtask

  task automatic req(input logic w, input logic r, input logic [3:0] a);
    req_wr_i   = w;
    req_rd_i   = r;
    req_addr_i = a;
    tick();
    req_wr_i = 1'b0;
    req_rd_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cbus_cmd_i = NOP; cbus_addr_i = '0;
    req_wr_i = 1'b0; req_rd_i = 1'b0; req_addr_i = '0;
    tick(); tick();
    chk("rst_lines", 64'(cache_state), 64'd0);
    chk("rst_ack", 64'(cbus_ack_o), 64'd0);
    chk("rst_flags", 64'({wr_proc_wait_for_en, rd_proc_wait_for_en}), 64'd0);
    chk("rst_memwr", 64'(mem_wr_o), 64'd0);
    chk("rst_hit", 64'(snoop_hit_cnt_o), 64'd0);
    rst = 1'b0;
    tick();

    // write request then enable
    req(1'b1, 1'b0, 4'd3);
    chk("wr_flag_set", 64'(wr_proc_wait_for_en), 64'd1);
    run_cmd(ENW, 4'd3, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("enw_ack_at", 64'(ack_at), 64'd2);
    chk("enw_ack_n", 64'(ack_n), 64'd1);
    chk("enw_line3", 64'(cache_state[3]), 64'(M));
    chk("enw_flag", 64'(wr_proc_wait_for_en), 64'd0);

    // dirty writeback on write snoop
    run_cmd(WRS, 4'd3, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("wrs_wb_n", 64'(wb_n), 64'd3);
    chk("wrs_wb_addr", 64'(addr_ok), 64'd1);
    chk("wrs_ack_at", 64'(ack_at), 64'd5);
    chk("wrs_line3", 64'(cache_state[3]), 64'(I));
    chk("wrs_hit", 64'(snoop_hit_cnt_o), 64'd1);

    // read request, enable, read snoop on E
    req(1'b0, 1'b1, 4'd5);
    chk("rd_flag_set", 64'(rd_proc_wait_for_en), 64'd1);
    run_cmd(ENR, 4'd5, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("enr_line5", 64'(cache_state[5]), 64'(E));
    chk("enr_flag", 64'(rd_proc_wait_for_en), 64'd0);
    run_cmd(RDS, 4'd5, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("rds_line5", 64'(cache_state[5]), 64'(S));
    chk("rds_wb_n", 64'(wb_n), 64'd0);
    chk("rds_ack_at", 64'(ack_at), 64'd2);
    chk("rds_hit", 64'(snoop_hit_cnt_o), 64'd2);

    // held broadcast without NOP: one ack only
    run_cmd(WRS, 4'd7, 6, wb_n, ack_at, ack_n, addr_ok);
    chk("hold_ack_n", 64'(ack_n), 64'd1);
    chk("hold_line7", 64'(cache_state[7]), 64'(I));
    chk("hold_hit", 64'(snoop_hit_cnt_o), 64'd2);

    // enable with nothing pending
    run_cmd(ENW, 4'd4, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("enw_nopend_line4", 64'(cache_state[4]), 64'(I));
    chk("enw_nopend_ack", 64'(ack_n), 64'd1);

    // out-of-range address
    run_cmd(WRS, 4'd12, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("oob_ack_at", 64'(ack_at), 64'd2);
    chk("oob_wb_n", 64'(wb_n), 64'd0);

    // read snoop on M: writeback then S
    req(1'b1, 1'b0, 4'd2);
    run_cmd(ENW, 4'd2, 1, wb_n, ack_at, ack_n, addr_ok);
    run_cmd(RDS, 4'd2, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("rdsm_wb_n", 64'(wb_n), 64'd3);
    chk("rdsm_line2", 64'(cache_state[2]), 64'(S));
    chk("rdsm_hit", 64'(snoop_hit_cnt_o), 64'd3);

    // enable address mismatch leaves flag pending
    req(1'b1, 1'b0, 4'd6);
    run_cmd(ENW, 4'd8, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("mis_line8", 64'(cache_state[8]), 64'(I));
    chk("mis_flag", 64'(wr_proc_wait_for_en), 64'd1);
    run_cmd(ENW, 4'd6, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("mis_line6", 64'(cache_state[6]), 64'(M));
    chk("mis_flag_clr", 64'(wr_proc_wait_for_en), 64'd0);

    // simultaneous requests: write wins
    req(1'b1, 1'b1, 4'd1);
    chk("both_flags", 64'({wr_proc_wait_for_en, rd_proc_wait_for_en}), 64'b10);
    run_cmd(ENW, 4'd1, 1, wb_n, ack_at, ack_n, addr_ok);
    chk("both_line1", 64'(cache_state[1]), 64'(M));

    // reset during second writeback cycle
    cbus_cmd_i = WRS; cbus_addr_i = 4'd1;
    tick(); tick(); tick();
    chk("mid_wb_active", 64'(mem_wr_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstwb_memwr", 64'(mem_wr_o), 64'd0);
    chk("rstwb_ack", 64'(cbus_ack_o), 64'd0);
    chk("rstwb_lines", 64'(cache_state), 64'd0);
    tick();
    chk("rstwb_ack2", 64'(cbus_ack_o), 64'd0);
    chk("rstwb_hit", 64'(snoop_hit_cnt_o), 64'd0);
    cbus_cmd_i = NOP;
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_ack", 64'(cbus_ack_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
